// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Build option BIN2BCD_OVF_SAT_EN: overflowed results read as all nines instead of all 4'hE nibbles.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int SW    = BCD_W + BIN_W;
  localparam int CW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;

`ifdef BIN2BCD_OVF_SAT_EN
  localparam logic [4*DIGITS-1:0] OVF_FILL = {DIGITS{4'h9}};
`else
  localparam logic [4*DIGITS-1:0] OVF_FILL = {DIGITS{4'hE}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [SW-1:0]        scratch_r, scratch_s, step_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic                 load_s;
  logic                 ovf_s;
  logic                 busy_r, done_r, ovf_r;
  logic [4*DIGITS-1:0]  bcd_r;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int i = 0; i < DIGITS + 1; i++) begin
      t[BIN_W+4*i +: 4] = (t[BIN_W+4*i +: 4] >= 4'd5) ? (t[BIN_W+4*i +: 4] + 4'd3)
                                                       : t[BIN_W+4*i +: 4];
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  assign step_s = dabble_step(scratch_r);
  // The extra top digit is non-zero only when the value does not fit in DIGITS digits.
  assign ovf_s  = (step_s[BIN_W+4*DIGITS +: 4] != 4'd0);

  // Next-state and datapath control.
  always_comb begin
    state_s   = state_r;
    scratch_s = scratch_r;
    cnt_s     = cnt_r;
    load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = SHIFT;
          scratch_s = {{BCD_W{1'b0}}, bin};
          cnt_s     = {CW{1'b0}};
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        scratch_s = step_s;
        cnt_s     = cnt_r + CW'(1);
        if (cnt_r == CW'(BIN_W - 1)) begin
          state_s = DONE;
          load_s  = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, scratch and registered outputs; results only update on the final shift.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r   <= IDLE;
      scratch_r <= {SW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_r     <= {(4*DIGITS){1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      scratch_r <= scratch_s;
      cnt_r     <= cnt_s;
      busy_r    <= (state_s != IDLE);
      done_r    <= (state_s == DONE);
      if (load_s) begin
        bcd_r <= ovf_s ? OVF_FILL : step_s[BIN_W +: 4*DIGITS];
        ovf_r <= ovf_s;
      end else begin
        bcd_r <= bcd_r;
        ovf_r <= ovf_r;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bcd_out = bcd_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: decimal-arithmetic reference model,
// per-cycle output comparison, directed literal checks and random conversions.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int MAXV   = 9999;

`ifdef BIN2BCD_OVF_SAT_EN
  localparam logic [15:0] FILL = 16'h9999;
`else
  localparam logic [15:0] FILL = 16'hEEEE;
`endif

  logic              clk = 1'b0;
  logic              clr_n = 1'b0;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin = '0;
  logic              busy, done, ovf;
  logic [15:0]       bcd_out;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc_fail_prints = 0;

  // Reference model state
  int          m_k = 0;
  int          m_val = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_bcd = 16'h0000;
  logic        m_ovf = 1'b0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Decimal conversion straight from arithmetic.
  function automatic void conv(input int v, output logic [15:0] b, output logic o);
    int p;
    b = 16'h0000;
    if (v > MAXV) begin
      o = 1'b1;
      b = FILL;
    end else begin
      o = 1'b0;
      p = v;
      for (int d = 0; d < DIGITS; d++) begin
        b[4*d +: 4] = 4'(p % 10);
        p = p / 10;
      end
    end
  endfunction

  // Timeline model: m_k counts edges since the accepting edge.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_k = 0; m_busy = 1'b0; m_done = 1'b0; m_bcd = 16'h0000; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_k == 0) begin
        if (start) begin
          m_val = int'(bin);
          m_k = 1;
        end
      end else if (m_k == BIN_W) begin
        conv(m_val, m_bcd, m_ovf);
        m_done = 1'b1;
        m_k = m_k + 1;
      end else if (m_k == BIN_W + 1) begin
        m_k = 0;
      end else begin
        m_k = m_k + 1;
      end
      m_busy = (m_k != 0);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    n_tests++;
    if ({busy, done, bcd_out, ovf} !== {m_busy, m_done, m_bcd, m_ovf}) begin
      n_fail++;
      if (n_cyc_fail_prints < 20) begin
        n_cyc_fail_prints++;
        $display("FAIL cycle_cmp t=%0t: got busy=%b done=%b bcd=%h ovf=%b, expected busy=%b done=%b bcd=%h ovf=%b",
                 $time, busy, done, bcd_out, ovf, m_busy, m_done, m_bcd, m_ovf);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_conv(input int v);
    @(negedge clk);
    bin = BIN_W'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin = BIN_W'($urandom);
  endtask

  task automatic wait_done(input string name, output int cyc);
    bit found;
    cyc = 0;
    found = 0;
    while (cyc < 40 && !found) begin
      @(negedge clk);
      cyc++;
      if (done) found = 1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, cyc);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_idle_timeout: got busy=1 after %0d cycles, expected 0", name, c);
    end
  endtask

  task automatic directed(input string name, input int v, input logic [15:0] eb, input logic eo);
    int cyc;
    start_conv(v);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    wait_done(name, cyc);
    chk({name, "_latency"}, 32'(cyc), 32'(BIN_W));
    chk({name, "_bcd"}, 32'(bcd_out), 32'(eb));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    wait_idle(name);
  endtask

  initial begin
    int cyc, cyc2, npulse, v;

    // Reset state and idle after release
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h0000);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    directed("c1234", 1234, 16'h1234, 1'b0);
    directed("c0", 0, 16'h0000, 1'b0);
    directed("c9999", 9999, 16'h9999, 1'b0);
    directed("c10000", 10000, FILL, 1'b1);
    directed("c16383", 16383, FILL, 1'b1);
    directed("c5", 5, 16'h0005, 1'b0);

    // Start and bin changes while busy are ignored
    start_conv(42);
    repeat (4) @(negedge clk);
    bin = BIN_W'(777);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    npulse = 0;
    for (int i = 0; i < 2 * BIN_W + 4; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("ignore_bcd", 32'(bcd_out), 32'h0042);
    chk("ignore_pulses", 32'(npulse), 32'd1);

    // Reset mid-conversion aborts without a done pulse
    start_conv(9000);
    repeat (6) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'h0000);
    @(negedge clk);
    clr_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < BIN_W + 4; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("abort_no_done", 32'(npulse), 32'd0);
    directed("c56", 56, 16'h0056, 1'b0);

    // start held high: next accept on the cycle after done
    @(negedge clk);
    bin = BIN_W'(1357);
    start = 1'b1;
    wait_done("held1", cyc);
    wait_done("held2", cyc2);
    start = 1'b0;
    chk("held_gap", 32'(cyc2), 32'(BIN_W + 2));
    chk("held_bcd", 32'(bcd_out), 32'h1357);
    wait_idle("held");

    // Random conversions with stray start pulses while busy
    for (int it = 0; it < 40; it++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                      : int'($urandom_range(0, 9999));
      start_conv(v);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        bin = BIN_W'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
